// File: rtl/spi_sclk_gen.sv
// SPI serial-clock generator: bursts of N SCLK cycles with run-time divisor,
// bit count, CPOL/CPHA, edge/sample/shift strobes, a CS-hold tail and abort.
module spi_sclk_gen #(
  parameter int DIV_W    = 8,
  parameter int CNT_W    = 6,
  parameter int RST_DIV  = 1,
  parameter int RST_BITS = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_cfg_we,
  input  logic [DIV_W-1:0] i_cfg_div,
  input  logic [CNT_W-1:0] i_cfg_bits,
  input  logic             i_cfg_cpol,
  input  logic             i_cfg_cpha,
  input  logic             i_start,
  input  logic             i_abort,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_sclk,
  output logic             o_lead_edge,
  output logic             o_trail_edge,
  output logic             o_sample,
  output logic             o_shift,
  output logic [CNT_W-1:0] o_bit_cnt
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_TAIL = 2'd2;

  localparam logic [DIV_W-1:0] LP_RST_DIV  = DIV_W'(RST_DIV);
  localparam logic [CNT_W-1:0] LP_RST_BITS = CNT_W'(RST_BITS);

  logic [1:0]       r_state;
  logic [DIV_W-1:0] r_div;
  logic [CNT_W-1:0] r_bits;
  logic             r_cpol;
  logic             r_cpha;
  logic [DIV_W-1:0] r_hcnt;
  logic [CNT_W:0]   r_ecnt;
  logic             r_sclk;
  logic             r_lead;
  logic             r_trail;
  logic             r_sample;
  logic             r_shift;
  logic             r_done;
  logic [CNT_W-1:0] r_bit_cnt;

  logic [DIV_W-1:0] w_hlast;
  logic [CNT_W:0]   w_elast;
  logic [CNT_W:0]   w_ecnt_nxt;
  logic             w_half_end;
  logic             w_next_lead;
  logic             w_next_trail;
  logic             w_is_last_edge;
  logic [CNT_W-1:0] w_bits_eff;
  logic             w_idle;
  logic             w_start_ok;
  logic             w_abort_now;
  logic             w_sample;

  // A divisor of 0 behaves as 1: the half-period always spans at least one cycle.
  assign w_hlast        = (r_div == '0) ? '0 : r_div - DIV_W'(1);
  assign w_elast        = {r_bits, 1'b0};
  assign w_ecnt_nxt     = r_ecnt + (CNT_W+1)'(1);
  assign w_half_end     = (r_hcnt == w_hlast);
  assign w_next_lead    = w_ecnt_nxt[0];
  assign w_next_trail   = ~w_ecnt_nxt[0];
  assign w_is_last_edge = (w_ecnt_nxt == w_elast);

  // A config write in the start cycle governs that burst, including its bit count.
  assign w_bits_eff  = i_cfg_we ? i_cfg_bits : r_bits;
  assign w_idle      = (r_state == S_IDLE);
  assign w_start_ok  = w_idle && i_start && (w_bits_eff != '0);
  assign w_abort_now = i_abort && !w_idle;

  // NOTE: synchronous reset: every register, configuration included, is
  // cleared only on an i_clk edge, and all state updates use non-blocking <=.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state  <= S_IDLE;
      r_div    <= LP_RST_DIV;
      r_bits   <= LP_RST_BITS;
      r_cpol   <= 1'b0;
      r_cpha   <= 1'b0;
      r_hcnt   <= '0;
      r_ecnt   <= '0;
      r_sclk   <= 1'b0;
      r_lead   <= 1'b0;
      r_trail  <= 1'b0;
      r_sample <= 1'b0;
      r_shift  <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_lead   <= 1'b0;
      r_trail  <= 1'b0;
      r_sample <= 1'b0;
      r_shift  <= 1'b0;
      r_done   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_cfg_we) begin
            r_div  <= i_cfg_div;
            r_bits <= i_cfg_bits;
            r_cpol <= i_cfg_cpol;
            r_cpha <= i_cfg_cpha;
          end
          r_sclk <= i_cfg_we ? i_cfg_cpol : r_cpol;
          r_hcnt <= '0;
          r_ecnt <= '0;
          if (w_start_ok) begin
            r_state <= S_RUN;
          end
        end

        S_RUN: begin
          if (i_abort) begin
            r_state <= S_IDLE;
            r_sclk  <= r_cpol;
            r_hcnt  <= '0;
          end else if (w_half_end) begin
            r_hcnt   <= '0;
            r_ecnt   <= w_ecnt_nxt;
            r_sclk   <= ~r_sclk;
            r_lead   <= w_next_lead;
            r_trail  <= w_next_trail;
            r_sample <= r_cpha ? w_next_trail : w_next_lead;
            // CPHA=0 has nothing left to shift after the final trailing edge.
            r_shift  <= r_cpha ? w_next_lead : (w_next_trail && !w_is_last_edge);
            if (w_is_last_edge) begin
              r_state <= S_TAIL;
            end
          end else begin
            r_hcnt <= r_hcnt + DIV_W'(1);
          end
        end

        S_TAIL: begin
          r_sclk <= r_cpol;
          if (i_abort) begin
            r_state <= S_IDLE;
            r_hcnt  <= '0;
          end else if (w_half_end) begin
            r_state <= S_IDLE;
            r_hcnt  <= '0;
            r_done  <= 1'b1;
          end else begin
            r_hcnt <= r_hcnt + DIV_W'(1);
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_sclk  <= r_cpol;
          r_hcnt  <= '0;
        end
      endcase
    end
  end

  // Strobes are masked in the cycle an abort is presented, so none escape.
  assign w_sample = r_sample && !w_abort_now;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_bit_cnt <= '0;
    end else if (w_start_ok) begin
      r_bit_cnt <= '0;
    end else if (w_sample) begin
      r_bit_cnt <= r_bit_cnt + CNT_W'(1);
    end
  end

  assign o_busy       = !w_idle;
  assign o_done       = r_done;
  assign o_sclk       = r_sclk;
  assign o_lead_edge  = r_lead && !w_abort_now;
  assign o_trail_edge = r_trail && !w_abort_now;
  assign o_sample     = w_sample;
  assign o_shift      = r_shift && !w_abort_now;
  assign o_bit_cnt    = r_bit_cnt;

endmodule

// File: tb/tb_spi_sclk_gen.sv
// Self-checking bench for spi_sclk_gen: directed vector table, hand-written
// corner sequences and randomized traffic against a cycle-arithmetic model.
module tb_spi_sclk_gen;

  localparam int DIV_W = 8;
  localparam int CNT_W = 6;

  logic             i_clk = 1'b0;
  logic             i_rst_n = 1'b0;
  logic             i_cfg_we = 1'b0;
  logic [DIV_W-1:0] i_cfg_div = '0;
  logic [CNT_W-1:0] i_cfg_bits = '0;
  logic             i_cfg_cpol = 1'b0;
  logic             i_cfg_cpha = 1'b0;
  logic             i_start = 1'b0;
  logic             i_abort = 1'b0;
  logic             o_busy;
  logic             o_done;
  logic             o_sclk;
  logic             o_lead_edge;
  logic             o_trail_edge;
  logic             o_sample;
  logic             o_shift;
  logic [CNT_W-1:0] o_bit_cnt;

  always #5 i_clk = ~i_clk;

  spi_sclk_gen #(.DIV_W(DIV_W), .CNT_W(CNT_W), .RST_DIV(1), .RST_BITS(8)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_cfg_we(i_cfg_we), .i_cfg_div(i_cfg_div),
    .i_cfg_bits(i_cfg_bits), .i_cfg_cpol(i_cfg_cpol), .i_cfg_cpha(i_cfg_cpha),
    .i_start(i_start), .i_abort(i_abort), .o_busy(o_busy), .o_done(o_done),
    .o_sclk(o_sclk), .o_lead_edge(o_lead_edge), .o_trail_edge(o_trail_edge),
    .o_sample(o_sample), .o_shift(o_shift), .o_bit_cnt(o_bit_cnt)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: outputs derived from the cycle offset since the accepted start.
  int  c = 0;
  bit  m_valid = 0;
  int  m_div, m_bits;
  bit  m_cpol, m_cpha;
  bit  m_act = 0;
  int  m_t, m_n, m_h;
  int  m_samp = 0;

  always @(negedge i_clk) begin
    bit e_busy, e_done, e_sclk, e_lead, e_trail, e_samp, e_shift;
    int rel, tot, k, eb;
    e_busy = 0; e_done = 0; e_lead = 0; e_trail = 0; e_samp = 0; e_shift = 0;
    e_sclk = m_cpol;
    if (m_valid) begin
      if (m_act) begin
        rel = c - (m_t + 1);
        tot = (2 * m_n + 1) * m_h;
        if (rel < tot) begin
          e_busy = 1;
          k = rel / m_h;
          e_sclk = m_cpol ^ (k % 2 == 1);
          if (rel > 0 && rel % m_h == 0) begin
            e_lead  = (k % 2 == 1);
            e_trail = !e_lead;
            e_samp  = m_cpha ? e_trail : e_lead;
            e_shift = m_cpha ? e_lead : (e_trail && k < 2 * m_n);
          end
          if (i_abort) begin
            e_lead = 0; e_trail = 0; e_samp = 0; e_shift = 0;
          end
        end else begin
          e_done = 1;
        end
      end
      check($sformatf("model cyc%0d {busy,done,sclk,lead,trail,sample,shift,cnt}", c),
            {o_busy, o_done, o_sclk, o_lead_edge, o_trail_edge, o_sample, o_shift, o_bit_cnt},
            {e_busy, e_done, e_sclk, e_lead, e_trail, e_samp, e_shift, CNT_W'(m_samp)});
    end
    if (!i_rst_n) begin
      m_valid = 1; m_act = 0; m_samp = 0;
      m_div = 1; m_bits = 8; m_cpol = 0; m_cpha = 0;
    end else if (m_valid) begin
      if (e_samp) m_samp++;
      if (e_busy && i_abort) begin
        m_act = 0;
      end else if (!e_busy) begin
        m_act = 0;
        eb = i_cfg_we ? int'(i_cfg_bits) : m_bits;
        if (i_cfg_we) begin
          m_div = int'(i_cfg_div); m_bits = int'(i_cfg_bits);
          m_cpol = i_cfg_cpol; m_cpha = i_cfg_cpha;
        end
        if (i_start && eb != 0) begin
          m_act = 1; m_t = c; m_samp = 0;
          m_n = m_bits; m_h = (m_div == 0) ? 1 : m_div;
        end
      end
    end
    c++;
  end

  task automatic next_cycle();
    @(posedge i_clk);
    #1;
  endtask

  task automatic burst(input int div, input int bits, input bit cpol, input bit cpha);
    i_cfg_we = 1; i_cfg_div = DIV_W'(div); i_cfg_bits = CNT_W'(bits);
    i_cfg_cpol = cpol; i_cfg_cpha = cpha; i_start = 1;
  endtask

  // Observes `limit` cycles after the current one; done_at is the offset of o_done (0 = none).
  task automatic measure(input int limit, output int busy_n, output int samp_n,
                         output int shift_n, output int lead_n, output int done_at);
    busy_n = 0; samp_n = 0; shift_n = 0; lead_n = 0; done_at = 0;
    for (int i = 1; i <= limit; i++) begin
      next_cycle();
      if (i == 1) begin
        i_cfg_we = 0; i_start = 0;
      end
      @(negedge i_clk);
      busy_n  += int'(o_busy);
      samp_n  += int'(o_sample);
      shift_n += int'(o_shift);
      lead_n  += int'(o_lead_edge);
      if (o_done && done_at == 0) done_at = i;
    end
  endtask

  typedef struct {
    int div; int bits; bit cpol; bit cpha;
    int exp_busy; int exp_samp; int exp_shift; int exp_lead; int exp_done_at; int exp_bitcnt;
  } vec_t;

  vec_t vecs[8];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int bn, sn, hn, ln, dn;

    vecs[0] = '{2,   8, 1'b0, 1'b0,   34,  8,  7,  8,   35,  8};
    vecs[1] = '{1,   4, 1'b1, 1'b1,    9,  4,  4,  4,   10,  4};
    vecs[2] = '{0,   4, 1'b1, 1'b1,    9,  4,  4,  4,   10,  4};
    vecs[3] = '{3,   1, 1'b0, 1'b0,    9,  1,  0,  1,   10,  1};
    vecs[4] = '{1,  63, 1'b0, 1'b1,  127, 63, 63, 63,  128, 63};
    vecs[5] = '{5,   3, 1'b1, 1'b0,   35,  3,  2,  3,   36,  3};
    vecs[6] = '{0,   0, 1'b1, 1'b0,    0,  0,  0,  0,    0,  3};
    vecs[7] = '{255, 2, 1'b1, 1'b1, 1275,  2,  2,  2, 1276,  2};

    repeat (3) next_cycle();
    i_rst_n = 1;
    next_cycle();
    @(negedge i_clk);
    check("reset busy/done/sclk/cnt", {o_busy, o_done, o_sclk, o_bit_cnt}, '0);

    for (int v = 0; v < 8; v++) begin
      next_cycle();
      burst(vecs[v].div, vecs[v].bits, vecs[v].cpol, vecs[v].cpha);
      measure(vecs[v].exp_busy + 4, bn, sn, hn, ln, dn);
      check($sformatf("vec%0d busy cycles", v), bn, vecs[v].exp_busy);
      check($sformatf("vec%0d samples", v), sn, vecs[v].exp_samp);
      check($sformatf("vec%0d shifts", v), hn, vecs[v].exp_shift);
      check($sformatf("vec%0d lead edges", v), ln, vecs[v].exp_lead);
      check($sformatf("vec%0d done offset", v), dn, vecs[v].exp_done_at);
      check($sformatf("vec%0d bit_cnt", v), o_bit_cnt, vecs[v].exp_bitcnt);
      check($sformatf("vec%0d idle sclk", v), o_sclk, vecs[v].cpol);
    end

    // Abort in cycle 10 of a div=2, bits=8 burst with cpol=1.
    next_cycle();
    burst(2, 8, 1'b1, 1'b0);
    for (int i = 1; i <= 10; i++) begin
      next_cycle();
      i_cfg_we = 0; i_start = 0;
    end
    i_abort = 1;
    next_cycle();
    i_abort = 0;
    @(negedge i_clk);
    check("abort busy cleared", o_busy, 1'b0);
    check("abort sclk to cpol", o_sclk, 1'b1);
    measure(40, bn, sn, hn, ln, dn);
    check("abort no strobes/done", {bn, sn, hn, ln, dn}, '0);

    // Reset at leading edge 5 of a div=3, bits=8 burst, then default config.
    next_cycle();
    burst(3, 8, 1'b1, 1'b0);
    for (int i = 1; i <= 16; i++) begin
      next_cycle();
      i_cfg_we = 0; i_start = 0;
    end
    i_rst_n = 0;
    next_cycle();
    i_rst_n = 1;
    @(negedge i_clk);
    check("midburst reset busy", o_busy, 1'b0);
    check("midburst reset sclk", o_sclk, 1'b0);
    next_cycle();
    i_start = 1;
    measure(22, bn, sn, hn, ln, dn);
    check("post-reset div=1 bits=8 busy", bn, 17);
    check("post-reset done offset", dn, 18);

    // Config write while running is ignored; cfg+start in IDLE takes effect.
    next_cycle();
    burst(1, 4, 1'b0, 1'b0);
    for (int i = 1; i <= 3; i++) begin
      next_cycle();
      i_cfg_we = 0; i_start = 0;
    end
    i_cfg_we = 1; i_cfg_div = 8'd5; i_cfg_bits = 6'd2; i_cfg_cpol = 1'b1;
    measure(12, bn, sn, hn, ln, dn);
    check("cfg during run: burst busy", bn + 3, 9);
    check("cfg during run: idle sclk", o_sclk, 1'b0);
    next_cycle();
    i_start = 1;
    measure(14, bn, sn, hn, ln, dn);
    check("next burst keeps old cfg", bn, 9);
    next_cycle();
    burst(5, 4, 1'b0, 1'b0);
    measure(50, bn, sn, hn, ln, dn);
    check("cfg+start applies div=5", bn, 45);

    // Randomized traffic; the model checks every cycle.
    for (int it = 0; it < 60; it++) begin
      next_cycle();
      i_cfg_we = ($urandom_range(0, 1) == 1);
      i_cfg_div = DIV_W'($urandom_range(0, 3));
      i_cfg_bits = CNT_W'($urandom_range(0, 9));
      i_cfg_cpol = 1'($urandom_range(0, 1));
      i_cfg_cpha = 1'($urandom_range(0, 1));
      i_start = ($urandom_range(0, 3) != 0);
      i_abort = ($urandom_range(0, 7) == 0);
      repeat ($urandom_range(5, 70)) begin
        next_cycle();
        i_cfg_we = ($urandom_range(0, 7) == 0);
        i_cfg_div = DIV_W'($urandom_range(0, 3));
        i_cfg_bits = CNT_W'($urandom_range(0, 9));
        i_cfg_cpol = 1'($urandom_range(0, 1));
        i_cfg_cpha = 1'($urandom_range(0, 1));
        i_start = ($urandom_range(0, 15) == 0);
        i_abort = ($urandom_range(0, 39) == 0);
      end
    end
    next_cycle();
    i_cfg_we = 0; i_start = 0; i_abort = 0;
    repeat (5) next_cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
